dct8_stream_core: RTL and testbench



---
 rtl/dct8_stream_core.sv | 192 +++++++++++++++++++
 tb/tb_dct8_stream_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct8_stream_core.sv
// Sequential 8-point 1-D DCT/IDCT: loads 8 samples, runs 64 MACs through an elaborated
// coefficient ROM, then streams 8 saturated results. Define DCT8_ROUND_EN for round-half-up.
module dct8_stream_core #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_W     = 12,
    parameter int unsigned COEF_W    = 14,
    parameter int unsigned COEF_FRAC = 12
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             mode_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [2:0]       out_idx_o,
    output logic             busy_o
);
    localparam int unsigned AccW = IN_W + COEF_W + 3;
    localparam int unsigned SumW = AccW + 1;

    // cos(m*pi/16) scaled by 2^30, folded onto the first quadrant by symmetry.
    function automatic longint cos_q30(input int m);
        int     r;
        longint v;
        logic   neg;
        r = m % 32;
        if (r > 16) r = 32 - r;
        neg = (r > 8);
        if (neg) r = 16 - r;
        case (r)
            0:       v = 64'sd1073741824;
            1:       v = 64'sd1053110176;
            2:       v = 64'sd992008094;
            3:       v = 64'sd892783698;
            4:       v = 64'sd759250125;
            5:       v = 64'sd596538995;
            6:       v = 64'sd410903207;
            7:       v = 64'sd209476638;
            default: v = 64'sd0;
        endcase
        return neg ? -v : v;
    endfunction

    // Entry k*8+n holds C[k][n], rounded half away from zero.
    function automatic logic [64*COEF_W-1:0] rom_init();
        logic [64*COEF_W-1:0] rom;
        longint               p, mag, q;
        rom = '0;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                p   = ((k == 0) ? 64'sd379625062 : 64'sd536870912) * cos_q30((2 * n + 1) * k);
                mag = (p < 0) ? -p : p;
                q   = (mag + (64'sd1 <<< (59 - COEF_FRAC))) >>> (60 - COEF_FRAC);
                if (p < 0) q = -q;
                rom[(k * 8 + n) * COEF_W +: COEF_W] = q[COEF_W-1:0];
            end
        end
        return rom;
    endfunction

    localparam logic [64*COEF_W-1:0] Rom = rom_init();
    localparam logic signed [SumW-1:0] SatMax = {{(SumW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SumW-1:0] SatMin = {{(SumW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef DCT8_ROUND_EN
    localparam logic signed [SumW-1:0] RoundAdd = SumW'(1) << (COEF_FRAC - 1);
`else
    localparam logic signed [SumW-1:0] RoundAdd = '0;
`endif

    typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

    state_e                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    mode_q, mode_d;
    logic [2:0]              icnt_q, icnt_d;
    logic [2:0]              ocnt_q, ocnt_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic signed [IN_W-1:0]  sbuf_q [8];
    logic signed [OUT_W-1:0] rbuf_q [8];
    logic                    load_we, rbuf_we;

    logic [5:0]              rom_idx;
    logic signed [COEF_W-1:0] coef;
    logic signed [AccW-1:0]  coef_x, samp_x, prod, mac_sum;
    logic signed [SumW-1:0]  sum, shifted;
    logic signed [OUT_W-1:0] result;

    // Inverse mode walks the ROM transposed: outer index is n, inner is k.
    assign rom_idx = mode_q ? {icnt_q, ocnt_q} : {ocnt_q, icnt_q};
    assign coef    = Rom[rom_idx*COEF_W +: COEF_W];
    assign coef_x  = AccW'(coef);
    assign samp_x  = AccW'(sbuf_q[icnt_q]);
    assign prod    = coef_x * samp_x;
    assign mac_sum = prod + ((icnt_q == 3'd0) ? '0 : acc_q);
    assign sum     = SumW'(mac_sum) + RoundAdd;
    assign shifted = sum >>> COEF_FRAC;

    always_comb begin
        result = shifted[OUT_W-1:0];
        if (shifted > SatMax) begin
            result = SatMax[OUT_W-1:0];
        end else if (shifted < SatMin) begin
            result = SatMin[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        mode_d      = mode_q;
        icnt_d      = icnt_q;
        ocnt_d      = ocnt_q;
        acc_d       = acc_q;
        load_we     = 1'b0;
        rbuf_we     = 1'b0;
        case (state_q)
            StLoad: begin
                in_ready_d = 1'b1;
                if (in_valid_i && in_ready_q) begin
                    load_we = 1'b1;
                    icnt_d  = icnt_q + 3'd1;
                    if (icnt_q == 3'd0) mode_d = mode_i;
                    if (icnt_q == 3'd7) begin
                        state_d    = StCompute;
                        in_ready_d = 1'b0;
                    end
                end
            end
            StCompute: begin
                acc_d  = mac_sum;
                icnt_d = icnt_q + 3'd1;
                if (icnt_q == 3'd7) begin
                    rbuf_we = 1'b1;
                    ocnt_d  = ocnt_q + 3'd1;
                    if (ocnt_q == 3'd7) begin
                        state_d     = StOutput;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StOutput: begin
                if (out_ready_i) begin
                    ocnt_d = ocnt_q + 3'd1;
                    if (ocnt_q == 3'd7) begin
                        state_d     = StLoad;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q     <= StLoad;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
            icnt_q      <= '0;
            ocnt_q      <= '0;
            acc_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                sbuf_q[i] <= '0;
                rbuf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
            icnt_q      <= icnt_d;
            ocnt_q      <= ocnt_d;
            acc_q       <= acc_d;
            if (load_we) sbuf_q[icnt_q] <= in_data_i;
            if (rbuf_we) rbuf_q[ocnt_q] <= result;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_valid_q ? rbuf_q[ocnt_q] : '0;
    assign out_idx_o   = out_valid_q ? ocnt_q : '0;
    assign busy_o      = (state_q != StLoad);

endmodule

// File: tb/tb_dct8_stream_core.sv
// Scoreboard bench for dct8_stream_core: a real-arithmetic DCT model feeds expected queues
// for a default instance and an OUT_W=8 instance; a monitor drains them under backpressure.
module tb_dct8_stream_core;
    localparam int F = 12;
`ifdef DCT8_ROUND_EN
    localparam longint Rnd = longint'(1) << (F - 1);
`else
    localparam longint Rnd = 0;
`endif

    logic        clk = 1'b0;
    logic        clr_n, mode, in_valid;
    logic [7:0]  in_data;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [11:0] out_data;
    logic [2:0]  out_idx;
    logic        s_in_ready, s_out_valid, s_busy;
    logic [7:0]  s_out_data;
    logic [2:0]  s_out_idx;

    always #5 clk = ~clk;

    dct8_stream_core u_dut (
        .clk_i(clk), .clr_ni(clr_n), .mode_i(mode), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_idx_o(out_idx), .busy_o(busy)
    );

    dct8_stream_core #(.OUT_W(8)) u_sat (
        .clk_i(clk), .clr_ni(clr_n), .mode_i(mode), .in_valid_i(in_valid),
        .in_ready_o(s_in_ready), .in_data_i(in_data), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .out_data_o(s_out_data), .out_idx_o(s_out_idx),
        .busy_o(s_busy)
    );

    typedef struct {
        int idx;
        int data;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   exp8_q[$];
    int     rom_m [8][8];
    int     checks = 0;
    int     errors = 0;
    int     stall_pct = 0;
    bit     lat_armed = 1'b0;
    longint hs_cyc = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic void build_rom();
        real ck, v;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                ck = (k == 0) ? $sqrt(0.125) : 0.5;
                v  = ck * $cos(real'((2 * n + 1) * k) * 3.14159265358979323846 / 16.0)
                     * real'(1 << F);
                rom_m[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
            end
        end
    endfunction

    function automatic int sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    task automatic push_expected(input int x[8], input bit md);
        longint acc;
        exp_t   e;
        for (int o = 0; o < 8; o++) begin
            acc = 0;
            for (int i = 0; i < 8; i++)
                acc += longint'(md ? rom_m[i][o] : rom_m[o][i]) * longint'(x[i]);
            acc   = (acc + Rnd) >>> F;
            e.idx = o;
            e.data = sat(acc, 12);
            exp_q.push_back(e);
            e.data = sat(acc, 8);
            exp8_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the 8th handshake.
    task automatic send_block(input int x[8], input bit md, input bit tog, input bit gaps);
        int w;
        push_expected(x, md);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = 8'(x[i]);
            mode     = (i == 0 || !tog) ? md : 1'($urandom_range(0, 1));
            w = 0;
            while (!in_ready && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (w >= 500) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", w);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        hs_cyc    = cyc;
        lat_armed = 1'b1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() > 0 || exp8_q.size() > 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sat_out_valid"}, s_out_valid, 0);
    endtask

    // Monitor: owns out_ready, checks hold stability, latency and scoreboard order.
    bit          held = 1'b0;
    bit          prev_valid = 1'b0;
    logic [11:0] h_data;
    logic [2:0]  h_idx;
    exp_t        me, ms;

    always @(negedge clk) begin
        if (!clr_n) begin
            held       = 1'b0;
            prev_valid = 1'b0;
            out_ready  = 1'b0;
        end else begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", $signed(out_data), $signed(h_data));
                chk("hold_idx", out_idx, h_idx);
            end
            if (out_valid && !prev_valid && lat_armed) begin
                chk("latency", cyc - hs_cyc, 64);
                lat_armed = 1'b0;
            end
            if (busy) begin
                chk("in_ready_busy", in_ready, 0);
                chk("sat_in_ready", s_in_ready, in_ready);
            end
            if (out_valid || s_out_valid) chk("sat_valid", s_out_valid, out_valid);
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_result: got idx %0d data %0d, required none",
                                 out_idx, $signed(out_data));
                    end else begin
                        me = exp_q.pop_front();
                        chk("out_idx", out_idx, me.idx);
                        chk("out_data", $signed(out_data), me.data);
                    end
                end else begin
                    held   = 1'b1;
                    h_data = out_data;
                    h_idx  = out_idx;
                end
            end
            if (s_out_valid && out_ready) begin
                if (exp8_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_sat_result: got data %0d, required none",
                             $signed(s_out_data));
                end else begin
                    ms = exp8_q.pop_front();
                    chk("sat_idx", s_out_idx, ms.idx);
                    chk("sat_data", $signed(s_out_data), ms.data);
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int x[8];
        build_rom();
        clr_n    = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        chk("in_ready_at_release", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);

        stall_pct = 0;
        x = '{default: 16};
        send_block(x, 1'b0, 1'b0, 1'b0);
        drain();
        x = '{100, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, 1'b0, 1'b0, 1'b0);
        drain();
        x = '{default: -16};
        send_block(x, 1'b0, 1'b0, 1'b0);
        drain();
        x = '{45, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, 1'b1, 1'b0, 1'b0);
        drain();
        x = '{default: 127};
        send_block(x, 1'b0, 1'b0, 1'b0);
        drain();
        x = '{default: -128};
        send_block(x, 1'b0, 1'b0, 1'b0);
        drain();

        stall_pct = 40;
        repeat (20) begin
            for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 255)) - 128;
            send_block(x, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        drain();

        stall_pct = 0;
        x = '{default: 16};
        send_block(x, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp8_q.delete();
        lat_armed = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        chk("midreset_in_ready_release", in_ready, 0);
        @(negedge clk);
        chk("midreset_in_ready_after", in_ready, 1);
        send_block(x, 1'b0, 1'b0, 1'b0);
        drain();

        repeat (100) @(negedge clk);
        chk("leftover_results", exp_q.size(), 0);
        chk("leftover_sat_results", exp8_q.size(), 0);
        chk("final_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
